// File: rtl/signal_capture_pkg.sv
// Shared types and default sizing for the signal window capture block.
package signal_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_POST    = 2'd1,
    ST_READOUT = 2'd2
  } capture_state_t;

  localparam int unsigned DEF_CHANNELS     = 16;
  localparam int unsigned DEF_PRE_SAMPLES  = 8;
  localparam int unsigned DEF_POST_SAMPLES = 24;
  localparam int unsigned DEF_DEPTH        = 64;

  localparam int unsigned HEADER_W = 16;

endpackage

// File: rtl/sample_ring_buffer.sv
// Simple dual-port sample store: one write port, registered read port with enable.
module sample_ring_buffer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register; cleared by reset so the stream data reads zero.
  always_ff @(posedge clk or posedge areset) begin
    if (areset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/signal_window_capture.sv
// Captures a pre/post-trigger window of the channel bus and streams it out.
// Optional macro SIGNAL_WINDOW_HEADER_EN prepends a 16-bit window sequence
// number beat to every window.
module signal_window_capture
  import signal_capture_pkg::*;
#(
  parameter int unsigned CHANNELS     = DEF_CHANNELS,
  parameter int unsigned PRE_SAMPLES  = DEF_PRE_SAMPLES,
  parameter int unsigned POST_SAMPLES = DEF_POST_SAMPLES,
  parameter int unsigned DEPTH        = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                areset,
  input  logic [CHANNELS-1:0] signals_i,
  input  logic                trigger_i,
  output logic [CHANNELS-1:0] m_data_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                m_last_o,
  output logic                armed_o,
  output logic                drop_o
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned WINDOW = PRE_SAMPLES + POST_SAMPLES + 1;
  localparam int unsigned BW     = $clog2(WINDOW + 1);
  localparam int unsigned PW     = $clog2(POST_SAMPLES + 1);
  localparam int unsigned FW     = $clog2(PRE_SAMPLES + 1);

  capture_state_t    state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     trig_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [FW-1:0]     fill;
  logic [PW-1:0]     post_cnt;
  logic [BW-1:0]     beat_cnt;
  logic [CHANNELS-1:0] rd_data;

  logic              wr_en_c;
  logic              rd_en_c;
  logic [AW-1:0]     rd_addr_c;
  logic              handshake_c;
  logic              start_c;
  logic              last_beat_c;
  logic [FW-1:0]     fill_next_c;

`ifdef SIGNAL_WINDOW_HEADER_EN
  logic                hdr_phase;
  logic [HEADER_W-1:0] seq_num;
`endif

  assign handshake_c = m_valid_o && m_ready_i;
  assign wr_en_c     = (state != ST_READOUT);
  assign start_c     = (state == ST_POST) && (post_cnt == PW'(POST_SAMPLES - 1));
  assign last_beat_c = (beat_cnt == BW'(WINDOW - 1));
  assign fill_next_c = (fill == FW'(PRE_SAMPLES)) ? fill : fill + FW'(1);

`ifdef SIGNAL_WINDOW_HEADER_EN
  assign m_data_o = hdr_phase ? CHANNELS'(seq_num) : rd_data;
`else
  assign m_data_o = rd_data;
`endif

  // Read issue: fetch the next sample whenever a new beat must be presented.
  always_comb begin
    rd_en_c   = 1'b0;
    rd_addr_c = rd_ptr;
`ifdef SIGNAL_WINDOW_HEADER_EN
    if ((state == ST_READOUT) && handshake_c) begin
      if (hdr_phase) begin
        rd_en_c   = 1'b1;
        rd_addr_c = rd_ptr;
      end else if (!last_beat_c) begin
        rd_en_c   = 1'b1;
        rd_addr_c = rd_ptr + AW'(1);
      end
    end
`else
    if (start_c) begin
      rd_en_c   = 1'b1;
      rd_addr_c = trig_ptr - AW'(PRE_SAMPLES);
    end else if ((state == ST_READOUT) && handshake_c && !last_beat_c) begin
      rd_en_c   = 1'b1;
      rd_addr_c = rd_ptr + AW'(1);
    end
`endif
  end

  sample_ring_buffer #(
    .WIDTH (CHANNELS),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk     (clk),
    .areset  (areset),
    .wr_en   (wr_en_c),
    .wr_addr (wr_ptr),
    .wr_data (signals_i),
    .rd_en   (rd_en_c),
    .rd_addr (rd_addr_c),
    .rd_data (rd_data)
  );

  // Capture FSM with pointers, counters and registered stream/status outputs.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      trig_ptr  <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      post_cnt  <= '0;
      beat_cnt  <= '0;
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      armed_o   <= 1'b0;
      drop_o    <= 1'b0;
`ifdef SIGNAL_WINDOW_HEADER_EN
      hdr_phase <= 1'b0;
      seq_num   <= '0;
`endif
    end else begin
      drop_o  <= trigger_i && !((state == ST_IDLE) && armed_o);
      armed_o <= 1'b0;
      if (wr_en_c) wr_ptr <= wr_ptr + AW'(1);

      case (state)
        ST_IDLE: begin
          if (trigger_i && armed_o) begin
            state    <= ST_POST;
            trig_ptr <= wr_ptr;
            post_cnt <= '0;
          end else begin
            fill    <= fill_next_c;
            armed_o <= (fill_next_c == FW'(PRE_SAMPLES));
          end
        end

        ST_POST: begin
          post_cnt <= post_cnt + PW'(1);
          if (start_c) begin
            state     <= ST_READOUT;
            rd_ptr    <= trig_ptr - AW'(PRE_SAMPLES);
            beat_cnt  <= '0;
            m_valid_o <= 1'b1;
            m_last_o  <= 1'b0;
`ifdef SIGNAL_WINDOW_HEADER_EN
            hdr_phase <= 1'b1;
`endif
          end
        end

        ST_READOUT: begin
          if (handshake_c) begin
`ifdef SIGNAL_WINDOW_HEADER_EN
            if (hdr_phase) begin
              hdr_phase <= 1'b0;
              m_last_o  <= 1'b0;
            end else
`endif
            if (last_beat_c) begin
              state     <= ST_IDLE;
              fill      <= '0;
              m_valid_o <= 1'b0;
              m_last_o  <= 1'b0;
`ifdef SIGNAL_WINDOW_HEADER_EN
              seq_num   <= seq_num + HEADER_W'(1);
`endif
            end else begin
              rd_ptr   <= rd_ptr + AW'(1);
              beat_cnt <= beat_cnt + BW'(1);
              m_last_o <= (beat_cnt == BW'(WINDOW - 2));
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
